// File: rtl/minisys_pkg.sv
// Shared Minisys-1A encodings: opcode/funct/rt/rs codes, the IO window tag and the
// registered control-word layout used by the decode controller.
package minisys_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_COP0   = 6'b010000;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_LBU    = 6'b100100;
   localparam logic [5:0] OP_LHU    = 6'b100101;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] F_SLL     = 6'b000000;
   localparam logic [5:0] F_SRL     = 6'b000010;
   localparam logic [5:0] F_SRA     = 6'b000011;
   localparam logic [5:0] F_SLLV    = 6'b000100;
   localparam logic [5:0] F_SRLV    = 6'b000110;
   localparam logic [5:0] F_SRAV    = 6'b000111;
   localparam logic [5:0] F_JR      = 6'b001000;
   localparam logic [5:0] F_JALR    = 6'b001001;
   localparam logic [5:0] F_SYSCALL = 6'b001100;
   localparam logic [5:0] F_BREAK   = 6'b001101;
   localparam logic [5:0] F_MFHI    = 6'b010000;
   localparam logic [5:0] F_MTHI    = 6'b010001;
   localparam logic [5:0] F_MFLO    = 6'b010010;
   localparam logic [5:0] F_MTLO    = 6'b010011;
   localparam logic [5:0] F_MULT    = 6'b011000;
   localparam logic [5:0] F_MULTU   = 6'b011001;
   localparam logic [5:0] F_DIV     = 6'b011010;
   localparam logic [5:0] F_DIVU    = 6'b011011;
   localparam logic [5:0] F_ADD     = 6'b100000;
   localparam logic [5:0] F_NOR     = 6'b100111;
   localparam logic [5:0] F_SLT     = 6'b101010;
   localparam logic [5:0] F_SLTU    = 6'b101011;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   localparam logic [4:0] RS_MFC0   = 5'b00000;
   localparam logic [4:0] RS_MTC0   = 5'b00100;

   localparam logic [31:0] ERET_WORD = 32'h42000018;
   localparam logic [21:0] IO_HIGH   = 22'h3FFFFF;

   typedef struct packed {
      logic       regdst, alusrc, memiotoreg, regwrite;
      logic       memwrite, memread, ioread, iowrite;
      logic       jmp, jal, jalr, jrn;
      logic       beq, bne, bgez, bgtz, blez, bltz, bgezal, bltzal;
      logic       mfhi, mflo, mfc0, mthi, mtlo, mtc0;
      logic       i_format, s_format, l_format, sftmd, div;
      logic [1:0] aluop;
      logic       mem_sign;
      logic [1:0] mem_dwidth;
      logic       brk, syscall, eret, rsvd;
   } ctrl_t;

endpackage

// File: rtl/control32_if.sv
// Instruction/steering inputs and decoded control strobes of the decode controller.
interface control32_if;
   logic [31:0] Instruction;
   logic        s_format, l_format;
   logic [21:0] Alu_resultHigh;

   logic Regdst, Alusrc, MemIOtoReg, RegWrite, MemWrite, MemRead, IORead, IOWrite;
   logic Jmp, Jal, Jalr, Jrn, Beq, Bne, Bgez, Bgtz, Blez, Bltz, Bgezal, Bltzal;
   logic Mfhi, Mflo, Mfc0, Mthi, Mtlo, Mtc0, I_format, S_format, L_format, Sftmd, Div;
   logic [1:0] ALUop, Mem_Dwidth;
   logic Mem_sign, Break, Syscall, Eret, Rsvd;

   modport master (
      output Instruction, s_format, l_format, Alu_resultHigh,
      input  Regdst, Alusrc, MemIOtoReg, RegWrite, MemWrite, MemRead, IORead, IOWrite,
      input  Jmp, Jal, Jalr, Jrn, Beq, Bne, Bgez, Bgtz, Blez, Bltz, Bgezal, Bltzal,
      input  Mfhi, Mflo, Mfc0, Mthi, Mtlo, Mtc0, I_format, S_format, L_format, Sftmd, Div,
      input  ALUop, Mem_Dwidth, Mem_sign, Break, Syscall, Eret, Rsvd
   );

   modport slave (
      input  Instruction, s_format, l_format, Alu_resultHigh,
      output Regdst, Alusrc, MemIOtoReg, RegWrite, MemWrite, MemRead, IORead, IOWrite,
      output Jmp, Jal, Jalr, Jrn, Beq, Bne, Bgez, Bgtz, Blez, Bltz, Bgezal, Bltzal,
      output Mfhi, Mflo, Mfc0, Mthi, Mtlo, Mtc0, I_format, S_format, L_format, Sftmd, Div,
      output ALUop, Mem_Dwidth, Mem_sign, Break, Syscall, Eret, Rsvd
   );
endinterface

// File: rtl/control32.sv
// Minisys-1A instruction decode controller: combinational decode of the current
// instruction and memory/IO steering, captured in one output register.
module control32 #(
   parameter logic [21:0] IO_HIGH = minisys_pkg::IO_HIGH
) (
   input logic       clock,
   input logic       reset,
   control32_if.slave bus
);
   import minisys_pkg::*;

   ctrl_t ctrl_d, ctrl_q;

   logic [5:0] op, funct;
   logic [4:0] rs, rt;
   logic       r, i_fmt, l_fmt, s_fmt, regimm, cop0, io_hit;
   logic       r_alu, r_ok, valid;

   assign op     = bus.Instruction[31:26];
   assign rs     = bus.Instruction[25:21];
   assign rt     = bus.Instruction[20:16];
   assign funct  = bus.Instruction[5:0];
   assign r      = (op == OP_RTYPE);
   assign regimm = (op == OP_REGIMM);
   assign cop0   = (op == OP_COP0);
   assign i_fmt  = (op[5:3] == 3'b001);
   assign l_fmt  = (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
   assign s_fmt  = (op inside {OP_SB, OP_SH, OP_SW});
   assign io_hit = (bus.Alu_resultHigh == IO_HIGH);

   // R-type functs that write rd through the ALU or shifter
   assign r_alu = r & (funct inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                                     [F_ADD:F_NOR], F_SLT, F_SLTU});
   assign r_ok  = r_alu | (r & (funct inside {F_JR, F_JALR, F_SYSCALL, F_BREAK,
                                              [F_MFHI:F_MTLO], [F_MULT:F_DIVU]}));

   assign valid = r_ok | i_fmt | l_fmt | s_fmt | (op inside {[OP_J:OP_BGTZ]})
                | (regimm & (rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL}))
                | (cop0 & (rs inside {RS_MFC0, RS_MTC0}))
                | (bus.Instruction == ERET_WORD);

   always_comb begin
      ctrl_d = '0;
      if (valid) begin
         ctrl_d.regdst     = r;
         ctrl_d.i_format   = i_fmt;
         ctrl_d.l_format   = l_fmt;
         ctrl_d.s_format   = s_fmt;
         ctrl_d.alusrc     = i_fmt | l_fmt | s_fmt;
         ctrl_d.memiotoreg = l_fmt;
         ctrl_d.jmp        = (op == OP_J);
         ctrl_d.jal        = (op == OP_JAL);
         ctrl_d.jrn        = r & (funct == F_JR);
         ctrl_d.jalr       = r & (funct == F_JALR);
         ctrl_d.beq        = (op == OP_BEQ);
         ctrl_d.bne        = (op == OP_BNE);
         ctrl_d.blez       = (op == OP_BLEZ);
         ctrl_d.bgtz       = (op == OP_BGTZ);
         ctrl_d.bltz       = regimm & (rt == RT_BLTZ);
         ctrl_d.bgez       = regimm & (rt == RT_BGEZ);
         ctrl_d.bltzal     = regimm & (rt == RT_BLTZAL);
         ctrl_d.bgezal     = regimm & (rt == RT_BGEZAL);
         ctrl_d.mfhi       = r & (funct == F_MFHI);
         ctrl_d.mthi       = r & (funct == F_MTHI);
         ctrl_d.mflo       = r & (funct == F_MFLO);
         ctrl_d.mtlo       = r & (funct == F_MTLO);
         ctrl_d.div        = r & (funct inside {F_DIV, F_DIVU});
         ctrl_d.sftmd      = r & (funct[5:3] == 3'b000);
         ctrl_d.syscall    = r & (funct == F_SYSCALL);
         ctrl_d.brk        = r & (funct == F_BREAK);
         ctrl_d.mfc0       = cop0 & (rs == RS_MFC0);
         ctrl_d.mtc0       = cop0 & (rs == RS_MTC0);
         ctrl_d.eret       = (bus.Instruction == ERET_WORD);
         ctrl_d.aluop[1]   = r | i_fmt;
         ctrl_d.aluop[0]   = ctrl_d.beq | ctrl_d.bne | ctrl_d.blez | ctrl_d.bgtz
                           | ctrl_d.bltz | ctrl_d.bgez | ctrl_d.bltzal | ctrl_d.bgezal;
         ctrl_d.regwrite   = i_fmt | l_fmt | r_alu | ctrl_d.jal | ctrl_d.jalr
                           | ctrl_d.bltzal | ctrl_d.bgezal | ctrl_d.mfc0
                           | ctrl_d.mfhi | ctrl_d.mflo;
         ctrl_d.mem_dwidth = (l_fmt | s_fmt) ? op[1:0] : 2'b00;
         ctrl_d.mem_sign   = l_fmt & ~op[2];
         // Steering follows the in-flight access flags, not the decoded opcode
         ctrl_d.memwrite   = bus.s_format & ~io_hit;
         ctrl_d.iowrite    = bus.s_format & io_hit;
         ctrl_d.memread    = bus.l_format & ~io_hit;
         ctrl_d.ioread     = bus.l_format & io_hit;
      end
      ctrl_d.rsvd = ~valid;
   end

   always_ff @(posedge clock) begin
      if (reset) ctrl_q <= '0;
      else       ctrl_q <= ctrl_d;
   end

   assign bus.Regdst     = ctrl_q.regdst;
   assign bus.Alusrc     = ctrl_q.alusrc;
   assign bus.MemIOtoReg = ctrl_q.memiotoreg;
   assign bus.RegWrite   = ctrl_q.regwrite;
   assign bus.MemWrite   = ctrl_q.memwrite;
   assign bus.MemRead    = ctrl_q.memread;
   assign bus.IORead     = ctrl_q.ioread;
   assign bus.IOWrite    = ctrl_q.iowrite;
   assign bus.Jmp        = ctrl_q.jmp;
   assign bus.Jal        = ctrl_q.jal;
   assign bus.Jalr       = ctrl_q.jalr;
   assign bus.Jrn        = ctrl_q.jrn;
   assign bus.Beq        = ctrl_q.beq;
   assign bus.Bne        = ctrl_q.bne;
   assign bus.Bgez       = ctrl_q.bgez;
   assign bus.Bgtz       = ctrl_q.bgtz;
   assign bus.Blez       = ctrl_q.blez;
   assign bus.Bltz       = ctrl_q.bltz;
   assign bus.Bgezal     = ctrl_q.bgezal;
   assign bus.Bltzal     = ctrl_q.bltzal;
   assign bus.Mfhi       = ctrl_q.mfhi;
   assign bus.Mflo       = ctrl_q.mflo;
   assign bus.Mfc0       = ctrl_q.mfc0;
   assign bus.Mthi       = ctrl_q.mthi;
   assign bus.Mtlo       = ctrl_q.mtlo;
   assign bus.Mtc0       = ctrl_q.mtc0;
   assign bus.I_format   = ctrl_q.i_format;
   assign bus.S_format   = ctrl_q.s_format;
   assign bus.L_format   = ctrl_q.l_format;
   assign bus.Sftmd      = ctrl_q.sftmd;
   assign bus.Div        = ctrl_q.div;
   assign bus.ALUop      = ctrl_q.aluop;
   assign bus.Mem_sign   = ctrl_q.mem_sign;
   assign bus.Mem_Dwidth = ctrl_q.mem_dwidth;
   assign bus.Break      = ctrl_q.brk;
   assign bus.Syscall    = ctrl_q.syscall;
   assign bus.Eret       = ctrl_q.eret;
   assign bus.Rsvd       = ctrl_q.rsvd;

endmodule

// File: tb/tb_control32.sv
// Bench for control32: directed instruction checks plus randomized instructions and
// steering inputs compared every cycle against a table-driven behavioural decode model.
module tb_control32;

   typedef struct packed {
      logic       regdst, alusrc, memiotoreg, regwrite;
      logic       memwrite, memread, ioread, iowrite;
      logic       jmp, jal, jalr, jrn;
      logic       beq, bne, bgez, bgtz, blez, bltz, bgezal, bltzal;
      logic       mfhi, mflo, mfc0, mthi, mtlo, mtc0;
      logic       i_format, s_format, l_format, sftmd, div;
      logic [1:0] aluop;
      logic       mem_sign;
      logic [1:0] mem_dwidth;
      logic       brk, syscall, eret, rsvd;
   } outs_t;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   control32_if bus();

   control32 dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   outs_t dut_out;
   assign dut_out = {bus.Regdst, bus.Alusrc, bus.MemIOtoReg, bus.RegWrite,
                     bus.MemWrite, bus.MemRead, bus.IORead, bus.IOWrite,
                     bus.Jmp, bus.Jal, bus.Jalr, bus.Jrn,
                     bus.Beq, bus.Bne, bus.Bgez, bus.Bgtz, bus.Blez, bus.Bltz,
                     bus.Bgezal, bus.Bltzal,
                     bus.Mfhi, bus.Mflo, bus.Mfc0, bus.Mthi, bus.Mtlo, bus.Mtc0,
                     bus.I_format, bus.S_format, bus.L_format, bus.Sftmd, bus.Div,
                     bus.ALUop, bus.Mem_sign, bus.Mem_Dwidth,
                     bus.Break, bus.Syscall, bus.Eret, bus.Rsvd};

   // Instruction-by-instruction table of what each supported encoding must assert
   function automatic outs_t model(input logic [31:0] ins, input logic s, input logic l,
                                   input logic [21:0] hi);
      outs_t e;
      bit    ok;
      int    op, rs, rt, fn;
      e  = '0;
      ok = 0;
      op = int'(ins[31:26]);
      rs = int'(ins[25:21]);
      rt = int'(ins[20:16]);
      fn = int'(ins[5:0]);
      case (op)
         0: begin
            e.regdst = 1; e.aluop = 2'b10;
            case (fn)
               0, 2, 3, 4, 6, 7: begin ok = 1; e.sftmd = 1; e.regwrite = 1; end
               8:  begin ok = 1; e.jrn = 1; end
               9:  begin ok = 1; e.jalr = 1; e.regwrite = 1; end
               12: begin ok = 1; e.syscall = 1; end
               13: begin ok = 1; e.brk = 1; end
               16: begin ok = 1; e.mfhi = 1; e.regwrite = 1; end
               17: begin ok = 1; e.mthi = 1; end
               18: begin ok = 1; e.mflo = 1; e.regwrite = 1; end
               19: begin ok = 1; e.mtlo = 1; end
               24, 25: ok = 1;
               26, 27: begin ok = 1; e.div = 1; end
               default: if ((fn >= 32 && fn <= 39) || fn == 42 || fn == 43) begin
                  ok = 1; e.regwrite = 1;
               end
            endcase
         end
         1: begin
            e.aluop = 2'b01;
            case (rt)
               0:  begin ok = 1; e.bltz = 1; end
               1:  begin ok = 1; e.bgez = 1; end
               16: begin ok = 1; e.bltzal = 1; e.regwrite = 1; end
               17: begin ok = 1; e.bgezal = 1; e.regwrite = 1; end
               default: ok = 0;
            endcase
         end
         2: begin ok = 1; e.jmp = 1; end
         3: begin ok = 1; e.jal = 1; e.regwrite = 1; end
         4: begin ok = 1; e.beq = 1;  e.aluop = 2'b01; end
         5: begin ok = 1; e.bne = 1;  e.aluop = 2'b01; end
         6: begin ok = 1; e.blez = 1; e.aluop = 2'b01; end
         7: begin ok = 1; e.bgtz = 1; e.aluop = 2'b01; end
         8, 9, 10, 11, 12, 13, 14, 15: begin
            ok = 1; e.i_format = 1; e.alusrc = 1; e.regwrite = 1; e.aluop = 2'b10;
         end
         16: begin
            if (ins == 32'h42000018) begin ok = 1; e.eret = 1; end
            else if (rs == 0) begin ok = 1; e.mfc0 = 1; e.regwrite = 1; end
            else if (rs == 4) begin ok = 1; e.mtc0 = 1; end
         end
         32, 33, 35, 36, 37: begin
            ok = 1; e.l_format = 1; e.alusrc = 1; e.memiotoreg = 1; e.regwrite = 1;
            e.mem_dwidth = 2'(op % 4);
            e.mem_sign   = (op < 36);
         end
         40, 41, 43: begin
            ok = 1; e.s_format = 1; e.alusrc = 1; e.mem_dwidth = 2'(op % 4);
         end
         default: ok = 0;
      endcase
      if (s) begin
         if (hi == 22'h3FFFFF) e.iowrite = 1; else e.memwrite = 1;
      end
      if (l) begin
         if (hi == 22'h3FFFFF) e.ioread = 1; else e.memread = 1;
      end
      if (!ok) begin
         e = '0;
         e.rsvd = 1;
      end
      return e;
   endfunction

   outs_t       exp_q;
   logic [31:0] exp_ins;
   bit          chk_en = 0;

   always @(posedge clock) begin
      exp_q   <= reset ? '0 : model(bus.Instruction, bus.s_format, bus.l_format,
                                    bus.Alu_resultHigh);
      exp_ins <= bus.Instruction;
      chk_en  <= 1'b1;
   end

   always @(negedge clock) begin
      if (chk_en) begin
         total++;
         if (dut_out !== exp_q) begin
            bad++;
            $display("FAIL model_cmp ins=%h got=%h want=%h", exp_ins, dut_out, exp_q);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, req);
      end
   endtask

   // Drive on the falling edge, return just after the edge that registers it
   task automatic exec(input logic [31:0] ins, input logic s, input logic l,
                       input logic [21:0] hi);
      @(negedge clock);
      bus.Instruction    = ins;
      bus.s_format       = s;
      bus.l_format       = l;
      bus.Alu_resultHigh = hi;
      @(posedge clock);
      #1;
   endtask

   logic [5:0] ops [17] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd12,
                            6'd15, 6'd16, 6'd32, 6'd35, 6'd37, 6'd41, 6'd43};
   logic [4:0] rts [5]  = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
   logic [4:0] rss [4]  = '{5'd0, 5'd4, 5'd16, 5'd9};

   function automatic logic [31:0] gen();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 5))
         0: ;
         1: w[31:26] = 6'd0;
         2: w[31:26] = ops[$urandom_range(0, 16)];
         3: begin w[31:26] = 6'd1; w[20:16] = rts[$urandom_range(0, 4)]; end
         4: begin w[31:26] = 6'd16; w[25:21] = rss[$urandom_range(0, 3)]; end
         default: w = ($urandom_range(0, 1) != 0) ? 32'h42000018 : 32'h0;
      endcase
      return w;
   endfunction

   initial begin
      reset              = 1'b1;
      bus.Instruction    = 32'h3c08ffff;
      bus.s_format       = 1'b0;
      bus.l_format       = 1'b0;
      bus.Alu_resultHigh = 22'h0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_all_zero", 64'(dut_out), 64'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("lui_i_format", 64'(dut_out.i_format), 1);
      chk("lui_alusrc",   64'(dut_out.alusrc), 1);
      chk("lui_regwrite", 64'(dut_out.regwrite), 1);
      chk("lui_aluop",    64'(dut_out.aluop), 2);
      chk("lui_rsvd",     64'(dut_out.rsvd), 0);

      exec(32'h01090018, 0, 0, 0);
      chk("mult_regdst", 64'(dut_out.regdst), 1);
      chk("mult_aluop", 64'(dut_out.aluop), 2);
      chk("mult_regwrite", 64'(dut_out.regwrite), 0);
      exec(32'h00005010, 0, 0, 0);
      chk("mfhi", 64'({dut_out.mfhi, dut_out.regwrite}), 2'b11);
      exec(32'h1500fffe, 0, 0, 0);
      chk("bne", 64'({dut_out.bne, dut_out.aluop}), 3'b101);
      exec(32'h04010001, 0, 0, 0);
      chk("bgez", 64'(dut_out.bgez), 1);
      exec(32'h05800001, 0, 0, 0);
      chk("bltz", 64'(dut_out.bltz), 1);
      exec(32'h05910002, 0, 0, 0);
      chk("bgezal", 64'({dut_out.bgezal, dut_out.regwrite}), 2'b11);
      exec(32'h05300003, 0, 0, 0);
      chk("bltzal", 64'({dut_out.bltzal, dut_out.regwrite}), 2'b11);
      exec(32'h19200001, 0, 0, 0);
      chk("blez", 64'(dut_out.blez), 1);
      exec(32'h1d200001, 0, 0, 0);
      chk("bgtz", 64'(dut_out.bgtz), 1);
      exec(32'h00000008, 0, 0, 0);
      chk("jr", 64'({dut_out.jrn, dut_out.regwrite}), 2'b10);
      exec(32'h08000054, 0, 0, 0);
      chk("j", 64'(dut_out.jmp), 1);
      exec(32'h0c000000, 0, 0, 0);
      chk("jal", 64'({dut_out.jal, dut_out.regwrite}), 2'b11);
      exec(32'hac000000, 1, 0, 22'h3FFFFF);
      chk("store_io", 64'({dut_out.iowrite, dut_out.memwrite}), 2'b10);
      exec(32'hac000000, 1, 0, 22'h0);
      chk("store_mem", 64'({dut_out.iowrite, dut_out.memwrite}), 2'b01);
      exec(32'h8c000000, 0, 1, 22'h3FFFFF);
      chk("load_io", 64'({dut_out.ioread, dut_out.memread}), 2'b10);
      exec(32'h8c000000, 0, 1, 22'h0);
      chk("load_mem", 64'({dut_out.ioread, dut_out.memread}), 2'b01);
      chk("lw_fields", 64'({dut_out.l_format, dut_out.memiotoreg, dut_out.mem_dwidth,
                            dut_out.mem_sign}), 5'b11111);
      exec(32'h42000018, 0, 0, 0);
      chk("eret", 64'(dut_out.eret), 1);
      exec(32'hfc000000, 0, 0, 0);
      chk("rsvd", 64'({dut_out.rsvd, dut_out.regwrite}), 2'b10);
      exec(32'h00000000, 0, 0, 0);
      chk("nop_valid", 64'(dut_out.rsvd), 0);

      // Reset asserted mid-stream clears everything on that edge
      @(negedge clock);
      reset = 1'b1;
      bus.Instruction = 32'h8c000000;
      @(posedge clock);
      #1;
      chk("midstream_reset", 64'(dut_out), 64'h0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         reset              = ($urandom_range(0, 63) == 0);
         bus.Instruction    = gen();
         bus.s_format       = 1'($urandom);
         bus.l_format       = 1'($urandom);
         bus.Alu_resultHigh = ($urandom_range(0, 1) != 0) ? 22'h3FFFFF : 22'($urandom);
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
